l2_stream_fetch: RTL and testbench



---
 rtl/msb_pkg.sv | 15 +
 rtl/base_incdec.sv | 38 +++
 rtl/l2_fetch_rob.sv | 62 ++++++
 rtl/l2_stream_fetch.sv | 179 +++++++++++++++++
 tb/tb_l2_stream_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msb_pkg.sv
// Shared definitions for the L2 stream fetch block.
// Holds the stream state enum, cacheline size and default widths.
package msb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } st_e;

    localparam int CL_BYTES = 128;
    localparam int EA_WIDTH = 57;
    localparam int NCL      = 16;

endpackage

// File: rtl/base_incdec.sv
// Up/down counter with synchronous clear.
// Ports: clk, reset (async high), i_clr, i_inc, i_dec, o_cnt.
module base_incdec #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_inc & ~i_dec)
            cnt_d = cnt_q + ONE;
        else if (~i_inc & i_dec)
            cnt_d = cnt_q - ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/l2_fetch_rob.sv
// Reorder bitmap, head pointer and in-order delivery handshake.
// Ports: clk, reset, i_init/i_head (stream start), i_rsp_v/i_rsp_tag
// (returning line), o_clrsp_v/i_clrsp_r (delivery), o_clrsp_hs, o_dup.
// Built only when L2_STREAM_FETCH_REORDER_EN is defined.
`ifdef L2_STREAM_FETCH_REORDER_EN
module l2_fetch_rob
    import msb_pkg::*;
#(
    parameter int ncl        = NCL,
    parameter int clid_width = $clog2(ncl)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_init,
    input  logic [clid_width-1:0] i_head,
    input  logic                  i_rsp_v,
    input  logic [clid_width-1:0] i_rsp_tag,
    output logic                  o_clrsp_v,
    input  logic                  i_clrsp_r,
    output logic                  o_clrsp_hs,
    output logic                  o_dup
);

    localparam logic [clid_width-1:0] ONE = clid_width'(1);

    logic [ncl-1:0]        vld_q;
    logic [ncl-1:0]        vld_d;
    logic [clid_width-1:0] head_q;
    logic [clid_width-1:0] head_d;

    assign o_clrsp_v  = vld_q[head_q];
    assign o_clrsp_hs = o_clrsp_v & i_clrsp_r;
    // Covers a repeat response and a response racing its own delivery.
    assign o_dup      = i_rsp_v & vld_q[i_rsp_tag];

    always_comb begin
        vld_d  = vld_q;
        head_d = head_q;
        if (o_clrsp_hs) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + ONE;
        end
        if (i_rsp_v)
            vld_d[i_rsp_tag] = 1'b1;
        if (i_init) begin
            vld_d  = '0;
            head_d = i_head;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            head_q <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
        end
    end

endmodule
`endif

// File: rtl/l2_stream_fetch.sv
// Per-stream L2 responder: turns L1 line requests into sequential host
// reads over [ea_b, ea_e) and returns in-order line-delivered strobes.
// Ports: stream init (i_rst_*), o_end, L1 request (i_clreq_*), host read
// (o_mreq_*), host response (i_mrsp_*), L1 delivery (o_clrsp_*), o_err.
// Macro L2_STREAM_FETCH_REORDER_EN enables out-of-order host responses.
module l2_stream_fetch
    import msb_pkg::*;
#(
    parameter int ncl        = NCL,
    parameter int clid_width = $clog2(ncl),
    parameter int ncl_width  = $clog2(ncl + 1),
    parameter int ea_width   = EA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rst_v,
    output logic                  i_rst_r,
    input  logic [ea_width-1:0]   i_rst_ea_b,
    input  logic [ea_width-1:0]   i_rst_ea_e,
    output logic                  o_end,
    input  logic                  i_clreq_v,
    output logic                  i_clreq_r,
    output logic                  o_mreq_v,
    input  logic                  o_mreq_r,
    output logic [ea_width-1:0]   o_mreq_ea,
    output logic [clid_width-1:0] o_mreq_tag,
    input  logic                  i_mrsp_v,
    input  logic [clid_width-1:0] i_mrsp_tag,
    output logic                  o_clrsp_v,
    input  logic                  o_clrsp_r,
    output logic                  o_err
);

    localparam logic [ncl_width-1:0] NCL_CNT   = ncl_width'(ncl);
    localparam logic [ncl_width-1:0] CNT_ONE   = ncl_width'(1);
    localparam logic [ea_width-1:0]  EA_ONE    = ea_width'(1);

    st_e                 state_q;
    logic [ea_width-1:0] ea_cur_q;
    logic [ea_width-1:0] ea_end_q;
    logic                err_q;
    logic                err_d;

    logic [ncl_width-1:0] pend;
    logic [ncl_width-1:0] outst;

    logic init;
    logic mreq_hs;
    logic last_hs;
    logic clreq_acc;
    logic pend_ovf;
    logic rsp_ok;
    logic rsp_err;
    logic clrsp_hs;

    assign init      = i_rst_v & (state_q == ST_IDLE);
    assign i_rst_r   = (state_q == ST_IDLE);
    assign i_clreq_r = 1'b1;
    assign o_end     = (state_q == ST_IDLE);
    assign o_err     = err_q;

    assign o_mreq_v   = (state_q == ST_FETCH) & (pend != '0) & (outst < NCL_CNT);
    assign o_mreq_ea  = ea_cur_q;
    assign o_mreq_tag = ea_cur_q[clid_width-1:0];
    assign mreq_hs    = o_mreq_v & o_mreq_r;
    assign last_hs    = mreq_hs & ((ea_cur_q + EA_ONE) == ea_end_q);

    // Requests outside FETCH are accepted and dropped.
    assign clreq_acc = i_clreq_v & (state_q == ST_FETCH);
    assign pend_ovf  = clreq_acc & ~mreq_hs & (pend == NCL_CNT);

    // Responses with nothing outstanding are stale and never reach the
    // delivery path.
    assign rsp_ok = i_mrsp_v & (outst != '0);

    base_incdec #(.W(ncl_width)) u_pend (
        .clk   (clk),
        .reset (reset),
        .i_clr (init | last_hs),
        .i_inc (clreq_acc & ~pend_ovf),
        .i_dec (mreq_hs),
        .o_cnt (pend)
    );

    base_incdec #(.W(ncl_width)) u_outst (
        .clk   (clk),
        .reset (reset),
        .i_clr (init),
        .i_inc (mreq_hs),
        .i_dec (clrsp_hs),
        .o_cnt (outst)
    );

`ifdef L2_STREAM_FETCH_REORDER_EN
    l2_fetch_rob #(
        .ncl        (ncl),
        .clid_width (clid_width)
    ) u_rob (
        .clk        (clk),
        .reset      (reset),
        .i_init     (init),
        .i_head     (i_rst_ea_b[clid_width-1:0]),
        .i_rsp_v    (rsp_ok),
        .i_rsp_tag  (i_mrsp_tag),
        .o_clrsp_v  (o_clrsp_v),
        .i_clrsp_r  (o_clrsp_r),
        .o_clrsp_hs (clrsp_hs),
        .o_dup      (rsp_err)
    );
`else
    localparam logic [clid_width-1:0] TAG_ONE = clid_width'(1);

    logic [clid_width-1:0] head_q;
    logic                  clrsp_v_q;

    // In-order host: each response is delivered the next cycle; L1 must
    // always be ready, so delivery counts as done regardless of ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            clrsp_v_q <= 1'b0;
        end else begin
            clrsp_v_q <= rsp_ok;
            if (init)
                head_q <= i_rst_ea_b[clid_width-1:0];
            else if (rsp_ok)
                head_q <= head_q + TAG_ONE;
        end
    end

    assign o_clrsp_v = clrsp_v_q;
    assign clrsp_hs  = clrsp_v_q;
    assign rsp_err   = (rsp_ok & (i_mrsp_tag != head_q))
                     | (clrsp_v_q & ~o_clrsp_r);
`endif

    always_comb begin
        err_d = err_q;
        if (init & (i_rst_ea_e < i_rst_ea_b))
            err_d = 1'b1;
        if (pend_ovf | rsp_err)
            err_d = 1'b1;
        if (i_mrsp_v & (outst == '0))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ea_cur_q <= '0;
            ea_end_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (init) begin
                        ea_cur_q <= i_rst_ea_b;
                        ea_end_q <= i_rst_ea_e;
                        state_q  <= (i_rst_ea_b < i_rst_ea_e) ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (mreq_hs) begin
                        ea_cur_q <= ea_cur_q + EA_ONE;
                        if (last_hs)
                            state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (clrsp_hs & (outst == CNT_ONE))
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_stream_fetch.sv
// Self-checking bench for l2_stream_fetch: directed scenarios plus
// randomized streams checked against a line-count reference model.
module tb_l2_stream_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rst_v;
    logic        i_rst_r;
    logic [56:0] i_rst_ea_b;
    logic [56:0] i_rst_ea_e;
    logic        o_end;
    logic        i_clreq_v;
    logic        i_clreq_r;
    logic        o_mreq_v;
    logic        o_mreq_r;
    logic [56:0] o_mreq_ea;
    logic [3:0]  o_mreq_tag;
    logic        i_mrsp_v;
    logic [3:0]  i_mrsp_tag;
    logic        o_clrsp_v;
    logic        o_clrsp_r;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    logic        s_mreq_v;
    logic        s_mhs;
    logic        s_clrsp_v;
    logic        s_chs;
    logic [56:0] s_ea;
    logic [3:0]  s_tag;

    always #5 clk = ~clk;

    l2_stream_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .i_rst_v    (i_rst_v),
        .i_rst_r    (i_rst_r),
        .i_rst_ea_b (i_rst_ea_b),
        .i_rst_ea_e (i_rst_ea_e),
        .o_end      (o_end),
        .i_clreq_v  (i_clreq_v),
        .i_clreq_r  (i_clreq_r),
        .o_mreq_v   (o_mreq_v),
        .o_mreq_r   (o_mreq_r),
        .o_mreq_ea  (o_mreq_ea),
        .o_mreq_tag (o_mreq_tag),
        .i_mrsp_v   (i_mrsp_v),
        .i_mrsp_tag (i_mrsp_tag),
        .o_clrsp_v  (o_clrsp_v),
        .o_clrsp_r  (o_clrsp_r),
        .o_err      (o_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc();
        #3;
        s_mreq_v  = o_mreq_v;
        s_mhs     = o_mreq_v & o_mreq_r;
        s_ea      = o_mreq_ea;
        s_tag     = o_mreq_tag;
        s_clrsp_v = o_clrsp_v;
        s_chs     = o_clrsp_v & o_clrsp_r;
        @(posedge clk);
        #1;
    endtask

    task automatic init(input logic [56:0] b, input logic [56:0] e);
        i_rst_v    = 1'b1;
        i_rst_ea_b = b;
        i_rst_ea_e = e;
        cyc();
        i_rst_v = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_end"}, 64'(o_end), 64'd1);
        chk({t, "_rst_r"}, 64'(i_rst_r), 64'd1);
        chk({t, "_mreq_v"}, 64'(o_mreq_v), 64'd0);
        chk({t, "_clrsp_v"}, 64'(o_clrsp_v), 64'd0);
        chk({t, "_err"}, 64'(o_err), 64'd0);
    endtask

    // Random stream model state
    logic [56:0] rb;
    logic [56:0] tmp;
    int len, acc, iss, dlv, n, k, idx, line;
    bit returned [32];
    int hostq [$];
    bit exp_mv;

    initial begin
        reset      = 1'b1;
        i_rst_v    = 1'b0;
        i_rst_ea_b = '0;
        i_rst_ea_e = '0;
        i_clreq_v  = 1'b0;
        o_mreq_r   = 1'b0;
        i_mrsp_v   = 1'b0;
        i_mrsp_tag = '0;
        o_clrsp_r  = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        chk_reset_vals("reset");
        chk("reset_clreq_r", 64'(i_clreq_r), 64'd1);

        // Four-line stream, over-requested
        init(57'h100, 57'h104);
        o_mreq_r = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            i_clreq_v = 1'b1;
            cyc();
            if (s_mhs) begin
                chk("a_ea", 64'(s_ea), 64'h100 + 64'(n));
                chk("a_tag", 64'(s_tag), 64'(n));
                n++;
            end
        end
        i_clreq_v = 1'b0;
        o_mreq_r  = 1'b0;
        chk("a_mreq_count", 64'(n), 64'd4);
        chk("a_not_end", 64'(o_end), 64'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            i_mrsp_v   = (i < 4);
            i_mrsp_tag = 4'(i);
            cyc();
            if (s_chs) n++;
        end
        i_mrsp_v = 1'b0;
        chk("a_clrsp_count", 64'(n), 64'd4);
        chk("a_end", 64'(o_end), 64'd1);
        chk("a_idle", 64'(i_rst_r), 64'd1);
        chk("a_err", 64'(o_err), 64'd0);

`ifdef L2_STREAM_FETCH_REORDER_EN
        // Reverse-order responses
        init(57'h100, 57'h104);
        o_mreq_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_clreq_v = (i < 4);
            cyc();
        end
        i_clreq_v = 1'b0;
        o_mreq_r  = 1'b0;
        for (int t = 3; t > 0; t--) begin
            i_mrsp_v   = 1'b1;
            i_mrsp_tag = 4'(t);
            cyc();
            chk("b_held", 64'(o_clrsp_v), 64'd0);
        end
        i_mrsp_tag = 4'd0;
        cyc();
        i_mrsp_v = 1'b0;
        chk("b_head_rsp", 64'(o_clrsp_v), 64'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (s_chs) n++;
        end
        chk("b_burst", 64'(n), 64'd4);
        chk("b_after", 64'(o_clrsp_v), 64'd0);
        chk("b_end", 64'(o_end), 64'd1);
        chk("b_err", 64'(o_err), 64'd0);
`endif

        // Empty stream
        init(57'h200, 57'h200);
        chk("c_end", 64'(o_end), 64'd1);
        chk("c_rst_r", 64'(i_rst_r), 64'd1);
        n = 0;
        o_mreq_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_clreq_v = 1'b1;
            cyc();
            if (s_mreq_v) n++;
        end
        i_clreq_v = 1'b0;
        o_mreq_r  = 1'b0;
        chk("c_no_mreq", 64'(n), 64'd0);
        chk("c_err", 64'(o_err), 64'd0);

        // Backpressure stability and tag wrap
        init(57'h10F, 57'h114);
        for (int i = 0; i < 2; i++) begin
            i_clreq_v = 1'b1;
            cyc();
        end
        i_clreq_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("d_hold_v", 64'(s_mreq_v), 64'd1);
            chk("d_hold_ea", 64'(s_ea), 64'h10F);
            chk("d_hold_tag", 64'(s_tag), 64'd15);
        end
        o_mreq_r = 1'b1;
        cyc();
        o_mreq_r = 1'b0;
        chk("d_next_v", 64'(o_mreq_v), 64'd1);
        chk("d_next_ea", 64'(o_mreq_ea), 64'h110);
        chk("d_next_tag", 64'(o_mreq_tag), 64'd0);
        do_reset();

        // Outstanding limit
        init(57'h300, 57'h314);
        o_mreq_r = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            i_clreq_v = (i < 20);
            cyc();
            if (s_mhs) n++;
        end
        i_clreq_v = 1'b0;
        chk("e_issued16", 64'(n), 64'd16);
        chk("e_stalled", 64'(o_mreq_v), 64'd0);
        i_mrsp_v   = 1'b1;
        i_mrsp_tag = 4'd0;
        cyc();
        i_mrsp_v = 1'b0;
        cyc();
        chk("e_clrsp", 64'(s_chs), 64'd1);
        chk("e_reopen", 64'(o_mreq_v), 64'd1);
        cyc();
        if (s_mhs) n++;
        chk("e_issued17", 64'(n), 64'd17);
        chk("e_stalled2", 64'(o_mreq_v), 64'd0);
        o_mreq_r = 1'b0;
        do_reset();

        // Randomized streams against the line-count model
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(1, 24);
            rb  = {25'($urandom_range(0, 4095)), 32'($urandom)};
            init(rb, rb + 57'(len));
            acc = 0;
            iss = 0;
            dlv = 0;
            foreach (returned[j]) returned[j] = 1'b0;
            hostq.delete();
            for (int c = 0; c < 2000 && dlv < len; c++) begin
                i_clreq_v = ($urandom_range(0, 1) == 1) && (acc < len)
                            && (acc - iss < 16);
                o_mreq_r  = ($urandom_range(0, 3) != 0);
                i_mrsp_v  = 1'b0;
                line      = -1;
                if (hostq.size() > 0 && $urandom_range(0, 2) != 0) begin
`ifdef L2_STREAM_FETCH_REORDER_EN
                    idx = $urandom_range(0, hostq.size() - 1);
`else
                    idx = 0;
`endif
                    line = hostq[idx];
                    hostq.delete(idx);
                    tmp        = rb + 57'(line);
                    i_mrsp_v   = 1'b1;
                    i_mrsp_tag = tmp[3:0];
                end
`ifdef L2_STREAM_FETCH_REORDER_EN
                o_clrsp_r = ($urandom_range(0, 2) != 0);
`else
                o_clrsp_r = 1'b1;
`endif
                cyc();
                exp_mv = (iss < len) && (acc > iss) && (iss - dlv < 16);
                chk("r_mreq_v", 64'(s_mreq_v), 64'(exp_mv));
                if (s_mreq_v) begin
                    tmp = rb + 57'(iss);
                    chk("r_ea", 64'(s_ea), 64'(tmp));
                    chk("r_tag", 64'(s_tag), 64'(tmp[3:0]));
                end
                chk("r_clrsp_v", 64'(s_clrsp_v), 64'(returned[dlv]));
                if (i_clreq_v) acc++;
                if (s_mhs) begin
                    hostq.push_back(iss);
                    iss++;
                end
                if (line >= 0) returned[line] = 1'b1;
                if (s_chs) dlv++;
            end
            i_clreq_v = 1'b0;
            o_mreq_r  = 1'b0;
            i_mrsp_v  = 1'b0;
            o_clrsp_r = 1'b1;
            chk("r_delivered", 64'(dlv), 64'(len));
            chk("r_end", 64'(o_end), 64'd1);
            chk("r_err", 64'(o_err), 64'd0);
        end

        // Duplicate response, then reset mid-stream
        init(57'h102, 57'h106);
        o_mreq_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_clreq_v = (i < 4);
            cyc();
        end
        i_clreq_v = 1'b0;
        o_mreq_r  = 1'b0;
        chk("f_err_pre", 64'(o_err), 64'd0);
        i_mrsp_v   = 1'b1;
        i_mrsp_tag = 4'd2;
        cyc();
        cyc();
        i_mrsp_v = 1'b0;
        chk("f_err_dup", 64'(o_err), 64'd1);
        repeat (3) cyc();
        chk("f_err_sticky", 64'(o_err), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("f_async");
        cyc();
        reset = 1'b0;
        cyc();
        chk_reset_vals("f_post");
        i_mrsp_v   = 1'b1;
        i_mrsp_tag = 4'd3;
        cyc();
        i_mrsp_v = 1'b0;
        chk("f_late_rsp", 64'(o_err), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
